// File: rtl/l2_arbiter.sv
// l2_arbiter: two-master (I-cache / D-cache) to single L2 port arbiter.
// Latency: 1 cycle of arbitration; a request seen in IDLE at cycle N is on the L2 port at N+1.
// Backpressure: requesters hold their request until resp; the grant is held until l2_resp.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   imem_*                I-side: read request, address, resp, rdata
//   dmem_*                D-side: read/write request, address, wdata, resp, rdata
//   l2_*                  L2 side: read/write command, address, wdata, resp, rdata
//   igrant_count,
//   dgrant_count          saturating grant counters (live only with L2_ARB_PERF_EN)
//
// Build option: define L2_ARB_PERF_EN to enable the grant counters; otherwise
// both counter outputs are tied to 0 and no counter flops exist.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-side
  input  logic                  imem_read,
  input  logic [ADDR_WIDTH-1:0] imem_address,
  output logic                  imem_resp,
  output logic [LINE_WIDTH-1:0] imem_rdata,
  // D-side
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [LINE_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_resp,
  output logic [LINE_WIDTH-1:0] dmem_rdata,
  // L2 side
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  // Performance counters
  output logic [15:0]           igrant_count,
  output logic [15:0]           dgrant_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_nxt;

  // 1 = the most recent grant went to the D-side.
  logic last_grant_d;

  // Command registers: the L2 port is driven only from these while serving.
  logic                  cmd_read;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [LINE_WIDTH-1:0] cmd_wdata;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = imem_read;
  assign d_req = dmem_read | dmem_write;

  // Next-state and grant decode.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time takes the grant.
        if (i_req && (!d_req || last_grant_d)) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping and command capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
      cmd_read     <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_address  <= '0;
      cmd_wdata    <= '0;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
      cmd_read     <= 1'b1;
      cmd_write    <= 1'b0;
      cmd_address  <= imem_address;
      cmd_wdata    <= '0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
      // Simultaneous read and write is treated as a write.
      cmd_read     <= dmem_read & ~dmem_write;
      cmd_write    <= dmem_write;
      cmd_address  <= dmem_address;
      cmd_wdata    <= dmem_wdata;
    end
  end

  // L2 command strobes are gated by state so IDLE (including right after a
  // reset abort) never issues anything.
  assign l2_read    = (state != IDLE) & cmd_read;
  assign l2_write   = (state != IDLE) & cmd_write;
  assign l2_address = cmd_address;
  assign l2_wdata   = cmd_wdata;

  // Response steering: only the granted side sees l2_resp; resp in IDLE is dropped.
  assign imem_resp  = (state == SERVE_I) & l2_resp;
  assign dmem_resp  = (state == SERVE_D) & l2_resp;
  assign imem_rdata = l2_rdata;
  assign dmem_rdata = l2_rdata;

`ifdef L2_ARB_PERF_EN
  logic [15:0] icnt;
  logic [15:0] dcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (grant_i && (icnt != 16'hFFFF)) begin
        icnt <= icnt + 16'd1;
      end
      if (grant_d && (dcnt != 16'hFFFF)) begin
        dcnt <= dcnt + 16'd1;
      end
    end
  end

  assign igrant_count = icnt;
  assign dgrant_count = dcnt;
`else
  assign igrant_count = 16'd0;
  assign dgrant_count = 16'd0;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the I/D to L2 arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_read;
  logic [AW-1:0] imem_address;
  logic          imem_resp;
  logic [LW-1:0] imem_rdata;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] dmem_address;
  logic [LW-1:0] dmem_wdata;
  logic          dmem_resp;
  logic [LW-1:0] dmem_rdata;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic          l2_resp;
  logic [LW-1:0] l2_rdata;
  logic [15:0]   igrant_count;
  logic [15:0]   dgrant_count;

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata),
    .igrant_count (igrant_count),
    .dgrant_count (dgrant_count)
  );

  always #5 clk = ~clk;

`ifdef L2_ARB_PERF_EN
  localparam bit PERF = 1'b1;
  localparam int NSAT = 65540;
`else
  localparam bit PERF = 1'b0;
  localparam int NSAT = 200;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the sampling point and check the four handshake outputs.
  task automatic obs(input string tag, input bit rd, input bit wr, input bit ir, input bit dr);
    @(negedge clk);
    chk({tag, ".l2_read"},   l2_read,   rd);
    chk({tag, ".l2_write"},  l2_write,  wr);
    chk({tag, ".imem_resp"}, imem_resp, ir);
    chk({tag, ".dmem_resp"}, dmem_resp, dr);
  endtask

  task automatic chk_counts(input string tag, input int ic, input int dc);
    int ie;
    int de;
    ie = PERF ? ((ic > 65535) ? 65535 : ic) : 0;
    de = PERF ? ((dc > 65535) ? 65535 : dc) : 0;
    chk({tag, ".igrant_count"}, igrant_count, ie);
    chk({tag, ".dgrant_count"}, dgrant_count, de);
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    imem_read    = 1'b0;
    imem_address = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    dmem_wdata   = '0;
    l2_resp      = 1'b0;
    l2_rdata     = {$urandom, $urandom, $urandom, $urandom};
    tick();
    reset = 1'b0;
    obs("rst", 0, 0, 0, 0);
    chk("rst.l2_address", l2_address, 0);
    chk("rst.l2_wdata", l2_wdata, 0);
    chk("rst.imem_rdata", imem_rdata, l2_rdata);
    chk("rst.dmem_rdata", dmem_rdata, l2_rdata);
    chk_counts("rst", 0, 0);
    tick();
  endtask

  // Transaction-level reference model.
  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t cur_q[$];     // transaction currently owning the L2 port (0 or 1 entries)
  bit   grant_log[$]; // history of winners since reset, 1 = D
  int   m_icnt;
  int   m_dcnt;

  logic [LW-1:0] wd;

  initial begin
    reset_dut();

    // Lone I-read.
    imem_read = 1'b1; imem_address = 16'h1230;
    obs("li.c0", 0, 0, 0, 0); tick();
    obs("li.c1", 1, 0, 0, 0); chk("li.c1.addr", l2_address, 16'h1230); tick();
    obs("li.c2", 1, 0, 0, 0); chk("li.c2.addr", l2_address, 16'h1230); tick();
    l2_resp = 1'b1; l2_rdata = 128'hA5;
    obs("li.c3", 1, 0, 1, 0); chk("li.c3.addr", l2_address, 16'h1230);
    chk("li.c3.imem_rdata", imem_rdata, 128'hA5);
    chk("li.c3.dmem_rdata", dmem_rdata, 128'hA5);
    tick();
    imem_read = 1'b0; l2_resp = 1'b0;
    obs("li.c4", 0, 0, 0, 0); tick();

    // Tie right after reset: D first, one IDLE cycle, then I.
    reset_dut();
    wd = {$urandom, $urandom, $urandom, $urandom};
    imem_read = 1'b1; imem_address = 16'h2000;
    dmem_write = 1'b1; dmem_address = 16'h3000; dmem_wdata = wd;
    obs("tie.c0", 0, 0, 0, 0); tick();
    l2_resp = 1'b1;
    obs("tie.c1", 0, 1, 0, 1);
    chk("tie.c1.addr", l2_address, 16'h3000); chk("tie.c1.wdata", l2_wdata, wd);
    tick();
    dmem_write = 1'b0; l2_resp = 1'b0;
    obs("tie.c2", 0, 0, 0, 0); tick();
    l2_resp = 1'b1;
    obs("tie.c3", 1, 0, 1, 0);
    chk("tie.c3.addr", l2_address, 16'h2000); chk("tie.c3.wdata", l2_wdata, 0);
    tick();
    imem_read = 1'b0; l2_resp = 1'b0;
    obs("tie.c4", 0, 0, 0, 0); tick();

    // Continuous contention: D, I, D, I.
    reset_dut();
    imem_read = 1'b1; dmem_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
      exp_d = (k % 2) == 0;
      obs($sformatf("alt%0d.idle", k), 0, 0, 0, 0); tick();
      l2_resp = 1'b1;
      obs($sformatf("alt%0d.serve", k), !exp_d, exp_d, !exp_d, exp_d); tick();
      l2_resp = 1'b0;
    end
    imem_read = 1'b0; dmem_write = 1'b0;
    obs("alt.end", 0, 0, 0, 0);
    chk_counts("alt", 2, 2);
    tick();

    // Address change during SERVE_D must not reach the L2 port.
    dmem_read = 1'b1; dmem_address = 16'h0040;
    obs("hold.c0", 0, 0, 0, 0); tick();
    dmem_address = 16'h0080;
    obs("hold.c1", 1, 0, 0, 0); chk("hold.c1.addr", l2_address, 16'h0040); tick();
    obs("hold.c2", 1, 0, 0, 0); chk("hold.c2.addr", l2_address, 16'h0040); tick();
    l2_resp = 1'b1;
    obs("hold.c3", 1, 0, 0, 1); chk("hold.c3.addr", l2_address, 16'h0040); tick();
    dmem_read = 1'b0; l2_resp = 1'b0;
    obs("hold.c4", 0, 0, 0, 0); tick();

    // Reset in the middle of SERVE_I aborts the transaction.
    imem_read = 1'b1; imem_address = 16'h5555;
    obs("abort.c0", 0, 0, 0, 0); tick();
    obs("abort.c1", 1, 0, 0, 0); tick();
    reset = 1'b1; imem_read = 1'b0;
    tick();
    reset = 1'b0; l2_resp = 1'b1;
    obs("abort.c3", 0, 0, 0, 0); chk_counts("abort", 0, 0); tick();
    l2_resp = 1'b0;
    obs("abort.c4", 0, 0, 0, 0); tick();

    // Long run of I-grants for counter saturation.
    reset_dut();
    imem_read = 1'b1; l2_resp = 1'b1;
    repeat (2 * NSAT) tick();
    imem_read = 1'b0; l2_resp = 1'b0;
    @(negedge clk);
    chk_counts("sat", NSAT, 0);
    tick();

    // Randomized traffic against the model.
    reset_dut();
    begin
      bit i_pend;
      bit d_pend;
      int d_kind;
      i_pend = 1'b0; d_pend = 1'b0; d_kind = 0;
      cur_q.delete(); grant_log.delete();
      m_icnt = 0; m_dcnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit   busy;
        txn_t t;
        if (!i_pend && ($urandom % 4 == 0)) begin
          i_pend = 1'b1;
          imem_address = AW'($urandom);
        end else if ($urandom % 8 == 0) begin
          imem_address = AW'($urandom);
        end
        if (!d_pend && ($urandom % 4 == 0)) begin
          d_pend = 1'b1;
          d_kind = $urandom_range(0, 2);
          dmem_address = AW'($urandom);
          dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end else if ($urandom % 8 == 0) begin
          dmem_address = AW'($urandom);
          dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        imem_read  = i_pend;
        dmem_read  = d_pend && (d_kind != 1);
        dmem_write = d_pend && (d_kind != 0);
        l2_resp    = ($urandom % 3) == 0;
        l2_rdata   = {$urandom, $urandom, $urandom, $urandom};

        busy = cur_q.size() != 0;
        if (busy) t = cur_q[0];
        @(negedge clk);
        chk("rnd.l2_read",   l2_read,   busy && !t.wr);
        chk("rnd.l2_write",  l2_write,  busy && t.wr);
        chk("rnd.imem_resp", imem_resp, busy && !t.is_d && l2_resp);
        chk("rnd.dmem_resp", dmem_resp, busy && t.is_d && l2_resp);
        chk("rnd.imem_rdata", imem_rdata, l2_rdata);
        chk("rnd.dmem_rdata", dmem_rdata, l2_rdata);
        if (busy) begin
          chk("rnd.l2_address", l2_address, t.addr);
          chk("rnd.l2_wdata",   l2_wdata,   t.wdata);
        end
        chk_counts("rnd", m_icnt, m_dcnt);

        // Advance the model by one clock edge.
        if (busy) begin
          if (l2_resp) begin
            void'(cur_q.pop_front());
            if (t.is_d) d_pend = 1'b0;
            else        i_pend = 1'b0;
          end
        end else if (imem_read || dmem_read || dmem_write) begin
          bit want_d;
          bit last_d;
          txn_t n;
          last_d = (grant_log.size() != 0) ? grant_log[$] : 1'b0;
          if (imem_read && (dmem_read || dmem_write)) want_d = !last_d;
          else                                        want_d = !imem_read;
          n.is_d  = want_d;
          n.wr    = want_d && dmem_write;
          n.addr  = want_d ? dmem_address : imem_address;
          n.wdata = want_d ? dmem_wdata : '0;
          cur_q.push_back(n);
          grant_log.push_back(want_d);
          if (want_d) m_dcnt++;
          else        m_icnt++;
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 16: width of all address ports (lc3b_word).
REQ-002 The block SHALL take parameter LINE_WIDTH, default 128: width of all line data ports.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have I-side ports: imem_read in 1; imem_address in ADDR_WIDTH; imem_resp out 1; imem_rdata out LINE_WIDTH.
REQ-006 The block SHALL have D-side ports: dmem_read in 1; dmem_write in 1; dmem_address in ADDR_WIDTH; dmem_wdata in LINE_WIDTH; dmem_resp out 1; dmem_rdata out LINE_WIDTH.
REQ-007 The block SHALL have L2-side ports: l2_read out 1; l2_write out 1; l2_address out ADDR_WIDTH; l2_wdata out LINE_WIDTH; l2_resp in 1; l2_rdata in LINE_WIDTH.
REQ-008 The block SHALL have ports igrant_count and dgrant_count, out, 16: grant counters (see Configuration).

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-010 In IDLE, the I-side request SHALL be imem_read, and the D-side request SHALL be dmem_read or dmem_write.
REQ-011 In IDLE, if only one side requests, the FSM SHALL enter that side's SERVE state on the next edge.
REQ-012 In IDLE, if both sides request, the side not granted last SHALL win; the last_grant flag SHALL record each grant.
REQ-013 On the grant edge, the block SHALL latch the winner's address, wdata (zero for I-side), and read/write into command registers.
REQ-014 In SERVE_x, l2_read, l2_write, l2_address and l2_wdata SHALL be driven only from the command registers.
REQ-015 In IDLE, l2_read and l2_write SHALL be 0.
REQ-016 Arbitration SHALL cost exactly 1 cycle: a request seen in IDLE at cycle N SHALL appear on the L2 port at cycle N+1.
REQ-017 In SERVE_x, l2_resp SHALL pass combinationally to the granted side's resp only; the other side's resp SHALL be 0.
REQ-018 imem_rdata and dmem_rdata SHALL both carry l2_rdata unconditionally.
REQ-019 On the edge where l2_resp=1 in SERVE_x, the FSM SHALL return to IDLE; back-to-back service therefore has 1 IDLE cycle between grants.
REQ-020 The grant SHALL be held until l2_resp, even if the requester deasserts; requesters hold requests until resp.
REQ-021 A request arriving for the other side during SERVE_x SHALL wait and be evaluated in the following IDLE cycle.
REQ-022 If dmem_read and dmem_write are both 1, the block SHALL treat it as a write.
REQ-023 l2_resp seen in IDLE SHALL be ignored.

Reset
REQ-024 When reset=1 at an edge, the block SHALL go to IDLE, clear the command registers, and set last_grant=I (first tie goes to D).
REQ-025 When reset=1 at an edge, the block SHALL set igrant_count=dgrant_count=0.
REQ-026 Reset asserted during SERVE_x SHALL abort the transaction: l2_read and l2_write SHALL be 0 from the next cycle, and no resp SHALL be forwarded.
REQ-027 All outputs SHALL be 0 in the cycle after reset, except imem_rdata and dmem_rdata, which follow l2_rdata.

Configuration
REQ-028 With macro L2_ARB_PERF_EN defined, igrant_count and dgrant_count SHALL increment on each I- or D-grant edge respectively and saturate at 16'hFFFF.
REQ-029 With L2_ARB_PERF_EN undefined, igrant_count and dgrant_count SHALL be tied to 0, no counter flops SHALL exist, and arbitration behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL apply a lone I-read: imem_read=1, address 16'h1230 at cycle 0, l2_resp at cycle 3 with rdata=128'hA5. Required: l2_read=1, l2_address=16'h1230 at cycles 1-3; imem_resp=1 only at cycle 3; dmem_resp=0 throughout.
REQ-031 The bench SHALL apply a tie after reset: imem_read and dmem_write both raised at cycle 0. Required: D served first (l2_write=1); after its resp, 1 IDLE cycle, then I served (l2_read=1).
REQ-032 The bench SHALL apply both sides requesting continuously for 4 transactions. Required: grants alternate D, I, D, I; with L2_ARB_PERF_EN, igrant_count=2 and dgrant_count=2.
REQ-033 The bench SHALL change dmem_address from 16'h0040 to 16'h0080 during SERVE_D. Required: l2_address stays 16'h0040 until l2_resp.
REQ-034 The bench SHALL assert reset 1 cycle during SERVE_I, then drive l2_resp=1 next cycle. Required: l2_read=0 after reset; imem_resp=0; FSM in IDLE.
REQ-035 The bench SHALL run 65540 I-grants with L2_ARB_PERF_EN defined. Required: igrant_count=16'hFFFF; without the macro, both counters read 0.
